kw_multibuf: RTL and testbench

- N-bank generalisation of the double buffer: a ring of NBANKS register-file banks, each DEPTH words.
- The producer fills one bank at a time and commits it. The consumer reads committed banks in commit order and releases each one back to the producer.
- Uses explicit commit/release handshakes and occupancy tracking in place of a blind swap. Sits between a block-oriented producer (e.g. a transform stage) and a consumer that needs random read access within a block.

---
 rtl/kw_multibuf.sv | 103 ++++++++++
 tb/tb_kw_multibuf.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/kw_multibuf.sv
// N-bank ring buffer. A block producer fills and commits banks, and a random-access consumer
// reads the committed banks in commit order and then releases them.
module kw_multibuf #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 16,
  parameter int NBANKS     = 3,
  parameter int ADDR_WIDTH = $clog2(DEPTH),
  parameter int BANK_WIDTH = $clog2(NBANKS),
  parameter int LVL_WIDTH  = $clog2(NBANKS + 1)
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  w_en_n,
  input  logic [ADDR_WIDTH-1:0] w_addr,
  input  logic [DATA_WIDTH-1:0] w_data,
  input  logic                  w_commit_n,
  output logic                  w_ready,
  output logic [BANK_WIDTH-1:0] w_bank,
  input  logic                  r_en_n,
  input  logic [ADDR_WIDTH-1:0] r_addr,
  output logic [DATA_WIDTH-1:0] r_data,
  input  logic                  r_release_n,
  output logic                  r_ready,
  output logic [BANK_WIDTH-1:0] r_bank,
  output logic [LVL_WIDTH-1:0]  level,
  output logic                  w_ovf,
  output logic                  r_udf
);

  // Each bank occupies a power-of-two slot, so {bank, addr} is the flat word index.
  localparam int SLOTS = 1 << ADDR_WIDTH;
  localparam int WORDS = NBANKS * SLOTS;
  localparam logic [BANK_WIDTH-1:0] LAST_BANK = BANK_WIDTH'(NBANKS - 1);
  localparam logic [LVL_WIDTH-1:0]  FULL      = LVL_WIDTH'(NBANKS);

  logic [BANK_WIDTH-1:0] wp;
  logic [BANK_WIDTH-1:0] rp;
  logic [LVL_WIDTH-1:0]  cnt;
  logic [DATA_WIDTH-1:0] mem [WORDS];
  logic [DATA_WIDTH-1:0] r_data_p1;
  logic                  w_ovf_q;
  logic                  r_udf_q;

  logic wr_go;
  logic commit_go;
  logic rd_go;
  logic release_go;
  logic w_bad;
  logic r_bad;

  function automatic logic [BANK_WIDTH-1:0] bank_inc(input logic [BANK_WIDTH-1:0] b);
    return (b == LAST_BANK) ? '0 : b + BANK_WIDTH'(1);
  endfunction

  assign w_ready    = (cnt != FULL);
  assign r_ready    = (cnt != '0);
  assign w_bank     = wp;
  assign r_bank     = rp;
  assign level      = cnt;
  assign r_data     = r_data_p1;
  assign w_ovf      = w_ovf_q;
  assign r_udf      = r_udf_q;

  assign wr_go      = !w_en_n && w_ready;
  assign commit_go  = !w_commit_n && w_ready;
  assign rd_go      = !r_en_n && r_ready;
  assign release_go = !r_release_n && r_ready;
  assign w_bad      = (!w_en_n || !w_commit_n) && !w_ready;
  assign r_bad      = (!r_en_n || !r_release_n) && !r_ready;

  // Occupancy control: pointers, committed count and sticky error flags.
  always_ff @(posedge clock) begin
    if (reset) begin
      wp      <= '0;
      rp      <= '0;
      cnt     <= '0;
      w_ovf_q <= 1'b0;
      r_udf_q <= 1'b0;
    end else begin
      if (commit_go)  wp <= bank_inc(wp);
      if (release_go) rp <= bank_inc(rp);
      case ({commit_go, release_go})
        2'b10:   cnt <= cnt + LVL_WIDTH'(1);
        2'b01:   cnt <= cnt - LVL_WIDTH'(1);
        default: cnt <= cnt;
      endcase
      if (w_bad) w_ovf_q <= 1'b1;
      if (r_bad) r_udf_q <= 1'b1;
    end
  end

  // Storage: the write lands in the producer bank, including on its commit cycle.
  always_ff @(posedge clock) begin
    if (!reset && wr_go) mem[{wp, w_addr}] <= w_data;
  end

  // Read stage p1: the registered read uses the pre-release rp.
  always_ff @(posedge clock) begin
    if (reset)      r_data_p1 <= '0;
    else if (rd_go) r_data_p1 <= mem[{rp, r_addr}];
  end

endmodule

// File: tb/tb_kw_multibuf.sv
// Scoreboard bench for kw_multibuf. An independent cycle model predicts the control state and
// queues the expected read data.
module tb_kw_multibuf;
  localparam int DW = 8;
  localparam int DEPTH = 16;
  localparam int NB = 3;
  localparam int AW = 4;
  localparam int BW = 2;
  localparam int LW = 2;

  logic          clock = 1'b0;
  logic          reset;
  logic          w_en_n, w_commit_n, r_en_n, r_release_n;
  logic [AW-1:0] w_addr, r_addr;
  logic [DW-1:0] w_data;
  logic          w_ready, r_ready, w_ovf, r_udf;
  logic [BW-1:0] w_bank, r_bank;
  logic [DW-1:0] r_data;
  logic [LW-1:0] level;

  always #5 clock = ~clock;

  kw_multibuf #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .NBANKS(NB)) dut (
    .clock(clock), .reset(reset),
    .w_en_n(w_en_n), .w_addr(w_addr), .w_data(w_data), .w_commit_n(w_commit_n),
    .w_ready(w_ready), .w_bank(w_bank),
    .r_en_n(r_en_n), .r_addr(r_addr), .r_data(r_data), .r_release_n(r_release_n),
    .r_ready(r_ready), .r_bank(r_bank),
    .level(level), .w_ovf(w_ovf), .r_udf(r_udf)
  );

  int n_cmp = 0;
  int n_bad = 0;

  logic [DW-1:0] sb_q[$];
  logic [DW-1:0] m_mem [NB][DEPTH];
  int            m_wp, m_rp, m_cnt;
  bit            m_wovf, m_rudf;
  logic [DW-1:0] m_rdata;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic idle_inputs();
    reset = 1'b0;
    w_en_n = 1'b1; w_commit_n = 1'b1; r_en_n = 1'b1; r_release_n = 1'b1;
    w_addr = '0; r_addr = '0; w_data = '0;
  endtask

  // Apply the currently driven inputs for one edge, update the model and compare.
  task automatic cycle();
    bit rd, wacc, racc;
    rd = 1'b0;
    if (reset) begin
      m_wp = 0; m_rp = 0; m_cnt = 0; m_wovf = 1'b0; m_rudf = 1'b0; m_rdata = '0;
      sb_q.delete();
    end else begin
      if ((!w_en_n || !w_commit_n) && m_cnt == NB) m_wovf = 1'b1;
      if ((!r_en_n || !r_release_n) && m_cnt == 0) m_rudf = 1'b1;
      if (!r_en_n && m_cnt != 0) begin
        sb_q.push_back(m_mem[m_rp][r_addr]);
        rd = 1'b1;
      end
      if (!w_en_n && m_cnt != NB) m_mem[m_wp][w_addr] = w_data;
      wacc = !w_commit_n && m_cnt != NB;
      racc = !r_release_n && m_cnt != 0;
      if (wacc) begin m_wp = (m_wp + 1) % NB; m_cnt = m_cnt + 1; end
      if (racc) begin m_rp = (m_rp + 1) % NB; m_cnt = m_cnt - 1; end
    end
    @(posedge clock);
    #1;
    if (rd) m_rdata = sb_q.pop_front();
    check("r_data", 32'(r_data), 32'(m_rdata));
    check("level", 32'(level), 32'(m_cnt));
    check("w_bank", 32'(w_bank), 32'(m_wp));
    check("r_bank", 32'(r_bank), 32'(m_rp));
    check("w_ready", 32'(w_ready), 32'(m_cnt != NB));
    check("r_ready", 32'(r_ready), 32'(m_cnt != 0));
    check("w_ovf", 32'(w_ovf), 32'(m_wovf));
    check("r_udf", 32'(r_udf), 32'(m_rudf));
    idle_inputs();
  endtask

  initial begin
    idle_inputs();
    reset = 1'b1;
    cycle();
    cycle();
    check("rst_w_ready", 32'(w_ready), 32'd1);
    check("rst_r_ready", 32'(r_ready), 32'd0);
    check("rst_level", 32'(level), 32'd0);
    check("rst_r_data", 32'(r_data), 32'd0);
    check("rst_flags", 32'({w_ovf, r_udf}), 32'd0);

    // Fill bank 0 with addr+0x10 and commit on the last write.
    for (int a = 0; a < DEPTH; a++) begin
      w_en_n = 1'b0; w_addr = AW'(a); w_data = DW'(a + 8'h10);
      if (a == DEPTH - 1) w_commit_n = 1'b0;
      cycle();
    end
    check("b0_level", 32'(level), 32'd1);
    check("b0_w_bank", 32'(w_bank), 32'd1);
    for (int a = 0; a < DEPTH; a++) begin
      r_en_n = 1'b0; r_addr = AW'(a);
      cycle();
      check("b0_read", 32'(r_data), 32'(a + 8'h10));
    end
    check("b0_r_bank", 32'(r_bank), 32'd0);

    // Fill banks 1 and 2 with no release, until the buffer is full.
    for (int b = 1; b < NB; b++) begin
      for (int a = 0; a < DEPTH; a++) begin
        w_en_n = 1'b0; w_addr = AW'(a); w_data = DW'(b * 8'h40 + a);
        if (a == DEPTH - 1) w_commit_n = 1'b0;
        cycle();
      end
    end
    check("full_level", 32'(level), 32'd3);
    check("full_w_ready", 32'(w_ready), 32'd0);
    w_en_n = 1'b0; w_addr = AW'(5); w_data = 8'hEE;
    cycle();
    check("full_ovf", 32'(w_ovf), 32'd1);
    r_en_n = 1'b0; r_addr = AW'(5);
    cycle();
    check("full_keep", 32'(r_data), 32'h15);

    // Commit and release together at full, then at level 1.
    w_commit_n = 1'b0; r_release_n = 1'b0;
    cycle();
    check("cr3_level", 32'(level), 32'd2);
    check("cr3_r_bank", 32'(r_bank), 32'd1);
    check("cr3_w_bank", 32'(w_bank), 32'd0);
    check("cr3_ovf", 32'(w_ovf), 32'd1);
    r_en_n = 1'b0; r_addr = AW'(7); r_release_n = 1'b0;
    cycle();
    check("rel_read", 32'(r_data), 32'h47);
    w_commit_n = 1'b0; r_release_n = 1'b0;
    cycle();
    check("cr1_level", 32'(level), 32'd1);
    check("cr1_w_bank", 32'(w_bank), 32'd1);
    check("cr1_r_bank", 32'(r_bank), 32'd0);

    // Pointer wrap: 7 commit/release pairs with a tag per pair.
    reset = 1'b1;
    cycle();
    for (int i = 0; i < 7; i++) begin
      check("wrap_w_bank", 32'(w_bank), 32'(i % NB));
      for (int a = 0; a < 4; a++) begin
        w_en_n = 1'b0; w_addr = AW'(a); w_data = DW'(i * 16 + a);
        if (a == 3) w_commit_n = 1'b0;
        cycle();
      end
      check("wrap_r_bank", 32'(r_bank), 32'(i % NB));
      for (int a = 0; a < 4; a++) begin
        r_en_n = 1'b0; r_addr = AW'(a);
        if (a == 3) r_release_n = 1'b0;
        cycle();
        check("wrap_tag", 32'(r_data), 32'(i * 16 + a));
      end
    end
    check("wrap_end_w", 32'(w_bank), 32'd1);
    check("wrap_end_r", 32'(r_bank), 32'd1);

    // Read and release while empty.
    r_en_n = 1'b0; r_addr = AW'(1); r_release_n = 1'b0;
    cycle();
    check("udf_hold", 32'(r_data), 32'h63);
    check("udf_flag", 32'(r_udf), 32'd1);
    check("udf_level", 32'(level), 32'd0);

    // Reset in the middle of a fill at level 2.
    for (int b = 0; b < 2; b++) begin
      w_en_n = 1'b0; w_addr = AW'(0); w_data = DW'(8'hC0 + b); w_commit_n = 1'b0;
      cycle();
    end
    check("mid_level", 32'(level), 32'd2);
    w_en_n = 1'b0; w_addr = AW'(2); w_data = 8'h99; reset = 1'b1;
    cycle();
    check("mid_rst_level", 32'(level), 32'd0);
    check("mid_rst_flags", 32'({w_ovf, r_udf}), 32'd0);
    check("mid_rst_r_data", 32'(r_data), 32'd0);
    cycle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
